// File: rtl/xrv_dbus_arb.sv
// Round-robin arbiter sharing one data-memory port among NM req/ready masters.
// Optional grant locking for atomic sequences is compiled in with XRV_ARB_LOCK_EN.
module xrv_dbus_arb #(
    parameter int NM     = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 0
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic [NM*AW-1:0]       m_addr,
    input  logic [NM-1:0]          m_wr_req,
    input  logic [NM-1:0]          m_rd_req,
    input  logic [NM*(DW/8)-1:0]   m_be,
    input  logic [NM*DW-1:0]       m_wr_data,
    output logic [NM-1:0]          m_wr_ready,
    output logic [NM-1:0]          m_rd_ready,
    output logic [DW-1:0]          m_rd_data,
    output logic [NM-1:0]          m_err,
`ifdef XRV_ARB_LOCK_EN
    input  logic [NM-1:0]          m_lock,
`endif
    output logic [AW-1:0]          d_addr,
    output logic                   d_wr_req,
    output logic                   d_rd_req,
    output logic [DW/8-1:0]        d_be,
    output logic [DW-1:0]          d_wr_data,
    input  logic                   d_wr_ready,
    input  logic                   d_rd_ready,
    input  logic [DW-1:0]          d_rd_data,
    output logic [$clog2(NM)-1:0]  grant_id,
    output logic                   arb_busy
);

    localparam int GW = $clog2(NM);
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic [TW-1:0]  to_q, to_d;

    logic [NM-1:0]  req_any;
    logic [GW-1:0]  pick;
    logic           pick_ok;
    int             pick_idx;

    logic           busy;
    logic           own_wr;
    logic           own_rd;
    logic           own_lock;
    logic           own_rdy;
    logic           own_abort;
    logic           to_hit;

    assign req_any = m_wr_req | m_rd_req;
    assign busy    = (state_q == BUSY);

    // Scan downwards so the requester closest to rr_q (at or after it) wins last.
    always_comb begin
        pick     = '0;
        pick_ok  = 1'b0;
        pick_idx = 0;
        for (int k = NM - 1; k >= 0; k--) begin
            pick_idx = int'(rr_q) + k;
            if (pick_idx >= NM) pick_idx = pick_idx - NM;
            if (req_any[pick_idx]) begin
                pick    = GW'(pick_idx);
                pick_ok = 1'b1;
            end
        end
    end

    assign own_wr = m_wr_req[gnt_q];
    assign own_rd = m_rd_req[gnt_q];

`ifdef XRV_ARB_LOCK_EN
    assign own_lock = m_lock[gnt_q];
`else
    assign own_lock = 1'b0;
`endif

    assign own_rdy   = busy && (d_wr_ready || d_rd_ready);
    assign own_abort = busy && !own_wr && !own_rd;
    // A ready in the final timeout cycle wins over the abort.
    assign to_hit    = (TO_CYC > 0) && busy && !own_abort && !own_rdy &&
                       (to_q == TW'(TO_CYC - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    state_d = BUSY;
                    gnt_d   = pick;
                    rr_d    = (int'(pick) == NM - 1) ? '0 : pick + 1'b1;
                    to_d    = '0;
                end
            end
            BUSY: begin
                if (own_rdy) begin
                    to_d = '0;
                    if (!own_lock) state_d = IDLE;
                end else if (own_abort || to_hit) begin
                    state_d = IDLE;
                    to_d    = '0;
                end else if (TO_CYC > 0) begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            to_q    <= to_d;
        end
    end

    // Outputs are held at zero while reset is asserted, whatever the slave does.
    always_comb begin
        d_addr     = '0;
        d_wr_req   = 1'b0;
        d_rd_req   = 1'b0;
        d_be       = '0;
        d_wr_data  = '0;
        m_wr_ready = '0;
        m_rd_ready = '0;
        m_err      = '0;
        m_rd_data  = '0;
        grant_id   = '0;
        arb_busy   = 1'b0;
        if (!rstb) begin
            m_rd_data = d_rd_data;
            grant_id  = gnt_q;
            arb_busy  = busy;
            if (busy) begin
                d_addr            = m_addr[int'(gnt_q)*AW +: AW];
                d_be              = m_be[int'(gnt_q)*(DW/8) +: DW/8];
                d_wr_data         = m_wr_data[int'(gnt_q)*DW +: DW];
                // A simultaneous read stays pending until the write has completed.
                d_wr_req          = own_wr && !to_hit;
                d_rd_req          = own_rd && !own_wr && !to_hit;
                m_wr_ready[gnt_q] = d_wr_ready;
                m_rd_ready[gnt_q] = d_rd_ready;
                m_err[gnt_q]      = to_hit;
            end
        end
    end

endmodule

// File: tb/tb_xrv_dbus_arb.sv
// Directed bench for xrv_dbus_arb with NM=3, TO_CYC=4; the lock sequence runs when
// XRV_ARB_LOCK_EN is defined.
module tb_xrv_dbus_arb;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rstb = 1'b1;
    logic [NM*AW-1:0]  m_addr = '0;
    logic [NM-1:0]     m_wr_req = '0;
    logic [NM-1:0]     m_rd_req = '0;
    logic [NM*4-1:0]   m_be = '0;
    logic [NM*DW-1:0]  m_wr_data = '0;
    logic [NM-1:0]     m_wr_ready;
    logic [NM-1:0]     m_rd_ready;
    logic [DW-1:0]     m_rd_data;
    logic [NM-1:0]     m_err;
    logic [NM-1:0]     m_lock = '0;
    logic [AW-1:0]     d_addr;
    logic              d_wr_req;
    logic              d_rd_req;
    logic [3:0]        d_be;
    logic [DW-1:0]     d_wr_data;
    logic              d_wr_ready;
    logic              d_rd_ready;
    logic [DW-1:0]     d_rd_data;
    logic [1:0]        grant_id;
    logic              arb_busy;

    int n_vec = 0;
    int n_err = 0;

    // Slave model: auto mode answers one cycle after a request; otherwise ready is manual.
    logic auto_slv = 1'b1;
    logic man_wr   = 1'b0;
    logic man_rd   = 1'b0;
    logic pend     = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk)
        pend <= auto_slv && (d_wr_req || d_rd_req) && !(d_wr_ready || d_rd_ready);

    assign d_wr_ready = auto_slv ? (pend && d_wr_req) : man_wr;
    assign d_rd_ready = auto_slv ? (pend && d_rd_req) : man_rd;
    assign d_rd_data  = 32'h1000 + {30'd0, d_addr[3:2]};

    xrv_dbus_arb #(.NM(NM), .AW(AW), .DW(DW), .TO_CYC(4)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .m_addr     (m_addr),
        .m_wr_req   (m_wr_req),
        .m_rd_req   (m_rd_req),
        .m_be       (m_be),
        .m_wr_data  (m_wr_data),
        .m_wr_ready (m_wr_ready),
        .m_rd_ready (m_rd_ready),
        .m_rd_data  (m_rd_data),
        .m_err      (m_err),
`ifdef XRV_ARB_LOCK_EN
        .m_lock     (m_lock),
`endif
        .d_addr     (d_addr),
        .d_wr_req   (d_wr_req),
        .d_rd_req   (d_rd_req),
        .d_be       (d_be),
        .d_wr_data  (d_wr_data),
        .d_wr_ready (d_wr_ready),
        .d_rd_ready (d_rd_ready),
        .d_rd_data  (d_rd_data),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] exp_rdy;

        m_addr   = {32'h108, 32'h104, 32'h100};
        m_rd_req = 3'b011;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            check("rst_d_rd_req", d_rd_req, 0);
            check("rst_d_addr", d_addr, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_rd_ready", m_rd_ready, 0);
            check("rst_busy", arb_busy, 0);
        end

        // Release reset with all three masters reading continuously.
        step(); rstb = 1'b0; m_rd_req = 3'b111; #1;
        check("rel_idle_rd_req", d_rd_req, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                exp_rdy = 3'b001 << i;
                if (r != 0 || i != 0) begin
                    step(); #1;
                    check("rr_idle_rd_req", d_rd_req, 0);
                end
                step(); #1;
                check("rr_grant_id", grant_id, i);
                check("rr_d_rd_req", d_rd_req, 1);
                check("rr_d_addr", d_addr, 32'h100 + 4 * i);
                check("rr_no_early_ready", m_rd_ready, 0);
                step(); #1;
                check("rr_rd_ready", m_rd_ready, exp_rdy);
                check("rr_rd_data", m_rd_data, 32'h1000 + i);
            end
        end
        step(); m_rd_req = 3'b000; #1;
        check("rr_end_idle", d_rd_req, 0);

        // Master 1 single write.
        step();
        m_addr[63:32]    = 32'h40;
        m_be[7:4]        = 4'b0011;
        m_wr_data[63:32] = 32'hDEADBEEF;
        m_wr_req         = 3'b010;
        #1;
        check("wr_idle", d_wr_req, 0);
        step(); #1;
        check("wr_grant_id", grant_id, 1);
        check("wr_d_wr_req", d_wr_req, 1);
        check("wr_d_rd_req", d_rd_req, 0);
        check("wr_d_addr", d_addr, 32'h40);
        check("wr_d_be", d_be, 4'b0011);
        check("wr_d_wr_data", d_wr_data, 32'hDEADBEEF);
        check("wr_no_early_ready", m_wr_ready, 0);
        step(); #1;
        check("wr_ready", m_wr_ready, 3'b010);
        step(); m_wr_req = 3'b000; m_addr[63:32] = 32'h104; #1;
        check("wr_after_ready", m_wr_ready, 0);
        check("wr_after_req", d_wr_req, 0);

        // Timeout with a silent slave: error in the 4th busy cycle.
        auto_slv = 1'b0;
        step(); m_rd_req = 3'b001; #1;
        for (int c = 1; c < 4; c++) begin
            step(); #1;
            check("to_rd_req", d_rd_req, 1);
            check("to_no_err", m_err, 0);
        end
        step(); #1;
        check("to_err", m_err, 3'b001);
        check("to_rd_req_drop", d_rd_req, 0);
        check("to_no_ready", m_rd_ready, 0);
        step(); m_rd_req = 3'b000; #1;
        check("to_err_once", m_err, 0);
        check("to_idle", arb_busy, 0);

        // Ready lands on the timeout cycle: completion wins.
        step(); m_rd_req = 3'b001; #1;
        for (int c = 1; c < 4; c++) begin
            step(); #1;
            check("tor_rd_req", d_rd_req, 1);
        end
        step(); man_rd = 1'b1; #1;
        check("tor_ready", m_rd_ready, 3'b001);
        check("tor_no_err", m_err, 0);
        check("tor_data", m_rd_data, 32'h1000);
        step(); man_rd = 1'b0; m_rd_req = 3'b000; #1;
        check("tor_after_err", m_err, 0);
        check("tor_idle", d_rd_req, 0);

        // Write and read together from master 0: write first, read after an idle cycle.
        auto_slv = 1'b1;
        step();
        m_wr_req        = 3'b001;
        m_rd_req        = 3'b001;
        m_wr_data[31:0] = 32'h12345678;
        m_be[3:0]       = 4'hF;
        #1;
        step(); #1;
        check("both_wr_fwd", d_wr_req, 1);
        check("both_rd_held", d_rd_req, 0);
        check("both_wr_data", d_wr_data, 32'h12345678);
        step(); #1;
        check("both_wr_ready", m_wr_ready, 3'b001);
        check("both_no_rd_ready", m_rd_ready, 0);
        check("both_rd_held2", d_rd_req, 0);
        step(); m_wr_req = 3'b000; #1;
        check("both_idle_wr", d_wr_req, 0);
        check("both_idle_rd", d_rd_req, 0);
        step(); #1;
        check("both_rd_fwd", d_rd_req, 1);
        check("both_wr_gone", d_wr_req, 0);
        step(); #1;
        check("both_rd_ready", m_rd_ready, 3'b001);
        check("both_rd_data", m_rd_data, 32'h1000);
        step(); m_rd_req = 3'b000; #1;
        check("both_end", d_rd_req, 0);

`ifdef XRV_ARB_LOCK_EN
        // Master 1 holds the port for three writes while master 0 waits.
        step();
        m_lock        = 3'b010;
        m_wr_req      = 3'b010;
        m_addr[63:32] = 32'h40;
        m_rd_req      = 3'b001;
        #1;
        check("lk_idle", d_wr_req, 0);
        for (int w = 0; w < 3; w++) begin
            step();
            if (w == 2) m_lock = 3'b000;
            #1;
            check("lk_grant_id", grant_id, 1);
            check("lk_wr_req", d_wr_req, 1);
            check("lk_rd_req", d_rd_req, 0);
            step(); #1;
            check("lk_grant_ready", grant_id, 1);
            check("lk_wr_ready", m_wr_ready, 3'b010);
        end
        step(); m_wr_req = 3'b000; #1;
        check("lk_release_idle", arb_busy, 0);
        step(); #1;
        check("lk_m0_grant", grant_id, 0);
        check("lk_m0_rd_req", d_rd_req, 1);
        step(); #1;
        check("lk_m0_ready", m_rd_ready, 3'b001);
        step(); m_rd_req = 3'b000; #1;
`endif

        // Reset during a busy read with ready high: no strobe, then idle.
        auto_slv = 1'b0;
        step(); m_rd_req = 3'b100; #1;
        step(); #1;
        check("mr_grant_id", grant_id, 2);
        check("mr_rd_req", d_rd_req, 1);
        step(); rstb = 1'b1; man_rd = 1'b1; #1;
        check("mr_rst_ready", m_rd_ready, 0);
        check("mr_rst_rd_req", d_rd_req, 0);
        step(); rstb = 1'b0; man_rd = 1'b0; m_rd_req = 3'b000; #1;
        check("mr_after_busy", arb_busy, 0);
        check("mr_after_grant", grant_id, 0);
        check("mr_after_rd_req", d_rd_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xrv_dbus_arb.md
# xrv_dbus_arb

Parametrised N-master arbiter that shares one `d_*` data-memory port among several requesters (xrv cores, DMA, debug) using the core's req/ready handshake. It sits between the masters' load/store ports and the single data memory, and grants the port round-robin. It adds one cycle of grant latency, aborts requests that time out, and optionally lets a master lock the port for atomic sequences.

## Interface
- `NM`, 2: number of masters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width; byte enables are `DW/8` wide.
- `TO_CYC`, 0: timeout in cycles for a granted request; 0 disables the timeout.
- `clk`  in  1  clock.
- `rstb`  in  1  synchronous reset, active-high (asserted = 1); the codebase name is kept.
- `m_addr`  in  NM*AW  per-master address; master i occupies slice i.
- `m_wr_req` / `m_rd_req`  in  NM each  per-master write/read request.
- `m_be`  in  NM*DW/8  per-master byte enables.
- `m_wr_data`  in  NM*DW  per-master write data.
- `m_wr_ready` / `m_rd_ready`  out  NM each  per-master completion strobe.
- `m_rd_data`  out  DW  read data, broadcast to all masters; only valid alongside `m_rd_ready[i]`.
- `m_err`  out  NM  one-cycle timeout-abort strobe.
- `m_lock`  in  NM  hold-grant request; present only with `XRV_ARB_LOCK_EN`.
- `d_addr`  out  AW, `d_wr_req` / `d_rd_req`  out  1, `d_be`  out  DW/8, `d_wr_data`  out  DW: slave port.
- `d_wr_ready` / `d_rd_ready`  in  1, `d_rd_data`  in  DW: slave responses.
- `grant_id`  out  $clog2(NM)  current owner; debug only.

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY: owner `gnt` is registered.
- IDLE, any master with `m_wr_req|m_rd_req`:
  - Select the first requester at or after `rr_ptr` (wrapping NM-1 to 0).
  - Register `gnt`, go to BUSY, set `rr_ptr <= gnt+1` (mod NM).
- BUSY, forwarding:
  - Slave outputs are a combinational mux of master `gnt`'s signals.
  - In IDLE all slave outputs are 0.
- Response routing:
  - `d_wr_ready` / `d_rd_ready` route only to `m_*_ready[gnt]`.
  - Non-owners always see ready = 0.
- Completion:
  - On slave ready, go to IDLE next cycle.
  - With lock held, stay BUSY instead (see Configuration).
- Both `m_wr_req` and `m_rd_req` high from the owner (protocol violation):
  - Forward the write only; `d_rd_req` is 0.
  - The read stays pending and is arbitrated again after the write completes.
- Abort: the owner drops both reqs before ready → IDLE next cycle with no strobe. The slave sees req fall.
- Timeout (`TO_CYC>0`):
  - `to_cnt` clears on entering BUSY and increments each BUSY cycle without ready.
  - At `to_cnt==TO_CYC-1` with no ready that cycle: pulse `m_err[gnt]` for 1 cycle, force slave reqs to 0 that cycle, go to IDLE.
  - Ready arriving in the same cycle as the timeout wins; no error is raised.
- `rr_ptr` wraps modulo NM for any NM, not only powers of two.

## Timing
- Reset values:
  - `d_*` outputs 0; `m_wr_ready`, `m_rd_ready`, `m_err` 0; `grant_id` 0.
  - State IDLE, `rr_ptr` 0, `to_cnt` 0.
- Reset asserted mid-transaction: next cycle is IDLE with all outputs 0, even if slave ready is high in that reset cycle.
- Grant latency:
  - Request first seen in cycle N → `d_*_req` high in cycle N+1.
  - Completion strobes are combinational, same cycle as slave ready.
- The master must hold req, addr, be and wr_data stable until its ready. It drops req in the cycle after ready.
- Unlocked throughput: one transaction per (slave latency + 2) cycles per grant.

## Configuration
- `XRV_ARB_LOCK_EN` defined:
  - `m_lock` port exists.
  - If `m_lock[gnt]` is high in the slave-ready cycle, the FSM stays BUSY with the same owner.
  - `rr_ptr` is not advanced.
  - The master's next request is forwarded without an IDLE bubble.
  - `to_cnt` restarts for each transaction.
  - The lock ends when ready is seen with `m_lock[gnt]` low.
- Undefined: no `m_lock` port; every completion returns to IDLE.

## Test plan
- Reset with masters 0 and 1 requesting: all outputs stay 0 during reset. The first grant after release goes to master 0; `d_addr` equals master 0's address in the cycle after release.
- NM=3, all masters issue continuous reads, slave ready 1 cycle after req: grant order is 0,1,2,0,1,2, and each `m_rd_ready[i]` pulse carries `d_rd_data` = 0x1000+i.
- Master 1 writes 0xDEADBEEF to 0x40 with be=4'b0011 while master 0 is idle: the slave sees exactly that write. `m_wr_ready[1]` pulses once and `m_wr_ready[0]` stays 0.
- `TO_CYC=4`, slave never ready: `m_err[gnt]` pulses exactly in the 4th BUSY cycle and `d_rd_req` falls in that cycle. With ready also in that cycle, no `m_err` is raised.
- Master 0 raises both `m_wr_req` and `m_rd_req`: the write completes first, then the read is granted after an IDLE cycle. `d_wr_req` and `d_rd_req` are never high together.
- `XRV_ARB_LOCK_EN`, master 1 locked for 3 back-to-back writes while master 0 requests: `grant_id` stays 1 across all 3 writes with no IDLE cycle between them. Master 0 is granted the cycle after the unlocked final ready.
